// File: rtl/multi_pattern_detector.sv
// Programmable multi-slot symbol-sequence detector with per-slot match pulses
// and saturating hit counters; supports overlap mode, idle gaps and a flush symbol.
module multi_pattern_detector #(
  parameter int SYM_W     = 2,
  parameter int MAX_LEN   = 5,
  parameter int N_PAT     = 4,
  parameter int COUNT_W   = 8,
  parameter int FLUSH_SYM = 3,
  parameter int IDX_W     = $clog2(N_PAT),
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sym_valid,
  input  logic [SYM_W-1:0]           sym,
  input  logic                       overlap_en,
  input  logic                       cfg_we,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [LEN_W-1:0]           cfg_len,
  input  logic [MAX_LEN*SYM_W-1:0]   cfg_pat,
  input  logic                       cnt_clear,
  output logic [N_PAT-1:0]           match,
  output logic                       match_any,
  output logic [N_PAT*COUNT_W-1:0]   hit_count,
  output logic [LEN_W-1:0]           fill
);

  // Only MAX_LEN-1 symbols are stored: the incoming symbol completes the window.
  logic [SYM_W-1:0]         hist_q [MAX_LEN-1];
  logic [SYM_W-1:0]         hist_d [MAX_LEN-1];
  logic [LEN_W-1:0]         fill_q, fill_d;
  logic [LEN_W-1:0]         len_q [N_PAT];
  logic [LEN_W-1:0]         len_d [N_PAT];
  logic [MAX_LEN*SYM_W-1:0] pat_q [N_PAT];
  logic [MAX_LEN*SYM_W-1:0] pat_d [N_PAT];
  logic [COUNT_W-1:0]       cnt_q [N_PAT];
  logic [COUNT_W-1:0]       cnt_d [N_PAT];
  logic [N_PAT-1:0]         match_q, match_d;
  logic                     match_any_q, match_any_d;

  logic [SYM_W-1:0]         cand [MAX_LEN];
  logic [LEN_W-1:0]         fill_plus;
  logic                     flush, accept, cfg_ok;
  logic [N_PAT-1:0]         hit;

  always_comb begin
    flush     = sym_valid && (sym == SYM_W'(FLUSH_SYM));
    accept    = sym_valid && !flush;
    cfg_ok    = cfg_we && (int'(cfg_idx) < N_PAT);
    fill_plus = (fill_q >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill_q + LEN_W'(1);
    cand[0]   = sym;
    for (int k = 1; k < MAX_LEN; k++) begin
      cand[k] = hist_q[k-1];
    end
    // A slot being rewritten this cycle is excluded from matching.
    for (int p = 0; p < N_PAT; p++) begin
      hit[p] = accept && (len_q[p] != '0) && (fill_plus >= len_q[p]) &&
               !(cfg_we && (cfg_idx == IDX_W'(p)));
      for (int k = 0; k < MAX_LEN; k++) begin
        if ((LEN_W'(k) < len_q[p]) && (cand[k] != pat_q[p][SYM_W*k +: SYM_W])) begin
          hit[p] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    hist_d      = hist_q;
    fill_d      = fill_q;
    match_d     = hit;
    match_any_d = |hit;
    len_d       = len_q;
    pat_d       = pat_q;
    cnt_d       = cnt_q;
    if (accept) begin
      hist_d[0] = sym;
      for (int k = 1; k < MAX_LEN - 1; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      fill_d = (!overlap_en && (|hit)) ? '0 : fill_plus;
    end else if (flush) begin
      fill_d = '0;
    end
    for (int p = 0; p < N_PAT; p++) begin
      if (cnt_clear) begin
        cnt_d[p] = '0;
      end else if (hit[p] && (cnt_q[p] != {COUNT_W{1'b1}})) begin
        cnt_d[p] = cnt_q[p] + COUNT_W'(1);
      end
      if (cfg_ok && (cfg_idx == IDX_W'(p))) begin
        len_d[p] = (cfg_len > LEN_W'(MAX_LEN)) ? '0 : cfg_len;
        pat_d[p] = cfg_pat;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_LEN - 1; k++) begin
        hist_q[k] <= '0;
      end
      for (int p = 0; p < N_PAT; p++) begin
        len_q[p] <= '0;
        pat_q[p] <= '0;
        cnt_q[p] <= '0;
      end
      fill_q      <= '0;
      match_q     <= '0;
      match_any_q <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      match_any_q <= match_any_d;
    end
  end

  always_comb begin
    for (int p = 0; p < N_PAT; p++) begin
      hit_count[COUNT_W*p +: COUNT_W] = cnt_q[p];
    end
  end

  assign match     = match_q;
  assign match_any = match_any_q;
  assign fill      = fill_q;

endmodule

// File: doc/multi_pattern_detector.md
Name: multi_pattern_detector

Overview:
- Parametrised, programmable successor to the fixed four-word letter-sequence FSM.
- Accepts one encoded symbol per valid cycle and compares the recent symbol history against N_PAT run-time-programmed patterns of up to MAX_LEN symbols.
- Drives a per-pattern registered match pulse and a saturating hit counter.
- Adds overlap/non-overlap mode, gap tolerance and a flush symbol. Sits between the symbol front end and the status/count logic.

Parameters:
- SYM_W, 2, symbol width. Default encoding: 0=l, 1=o, 2=v, 3=other.
- MAX_LEN, 5, maximum pattern length in symbols (>=2).
- N_PAT, 4, number of pattern slots (>=2).
- COUNT_W, 8, hit-counter width.
- FLUSH_SYM, 3, symbol code that clears history (the "other" input).
- IDX_W, $clog2(N_PAT), derived.
- LEN_W, $clog2(MAX_LEN+1), derived.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  symbol strobe; idle cycles are ignored.
- sym  in  SYM_W  input symbol.
- overlap_en  in  1  1=overlapping matches, 0=history consumed on match.
- cfg_we  in  1  pattern-slot write strobe.
- cfg_idx  in  IDX_W  slot to write.
- cfg_len  in  LEN_W  pattern length; 0 = slot disabled.
- cfg_pat  in  MAX_LEN*SYM_W  pattern; field k = bits [SYM_W*k +: SYM_W]; k=0 is the most recent symbol.
- cnt_clear  in  1  synchronous clear of all hit counters.
- match  out  N_PAT  registered one-cycle match pulse per slot.
- match_any  out  1  OR of match, registered.
- hit_count  out  N_PAT*COUNT_W  slot p at [COUNT_W*p +: COUNT_W].
- fill  out  LEN_W  number of valid history symbols, 0..MAX_LEN.

Behaviour:
- Reset (async, reset=0):
  - history, fill, match, match_any and all hit_count = 0.
  - All slots disabled (len=0, pat=0).
  - Outputs stay 0 while reset is held.
- History: hist[0..MAX_LEN-1], hist[0] newest. On an edge with sym_valid=1:
  - sym != FLUSH_SYM: shift sym into hist[0]; fill = min(fill+1, MAX_LEN).
  - sym == FLUSH_SYM: fill <= 0, no match this cycle. History contents are don't-care once fill=0.
  - sym_valid=0: no change. Gaps of any length do not break a sequence.
- Match condition for slot p, evaluated on the candidate history {sym, hist[0..]} at an accepting edge. All of the following must hold:
  - len_p != 0;
  - min(fill+1, MAX_LEN) >= len_p;
  - candidate[k] == pat_p[k] for k = 0..len_p-1;
  - no cfg_we to slot p in the same cycle.
- Latency: match[p] and match_any are registered at that edge and high for exactly one cycle. Back-to-back accepted symbols can produce back-to-back pulses.
- Non-overlap (overlap_en=0): if any slot matches at an edge, fill <= 0 instead of incrementing. All slots matching at that same edge still pulse.
- Overlap (overlap_en=1): fill is unaffected by matches.
- overlap_en is sampled per edge; changing it mid-stream is legal.
- Hit counters:
  - +1 on each match[p] set, saturating at 2^COUNT_W-1 (no wrap).
  - cnt_clear=1 forces all counters to 0 and takes priority over a simultaneous increment.
- Config writes:
  - cfg_we with cfg_idx < N_PAT latches len/pat at the edge.
  - cfg_idx >= N_PAT is ignored.
  - cfg_len > MAX_LEN is written as 0 (disabled).
  - Writes do not touch history, fill or counters.
  - The new pattern takes effect from the next edge.
- A pattern containing FLUSH_SYM in its active fields can never match. This is legal, not an error.
- Multiple slots may match at the same edge; each counts independently.

Test Plan:
- Program p0=l,o,l (len 3), p1=v,o,o,l, p2=v,o,l,v,o, p3=o,o,l,v,o; overlap_en=1; feed v,o,l,v,o -> match=4'b0100 for one cycle after the final o; hit_count[2]=1; all other counters 0; fill=5.
- Slots as above; feed v,o,o,l,v,o -> match[1] after l; match[3] after the final o; counts p1=1, p3=1, p0=0.
- p0=l,o,l; overlap_en=1; feed l,o,l,o,l -> match[0] after symbols 3 and 5; hit_count[0]=2. Repeat with overlap_en=0 -> single pulse after symbol 3; count=1; fill=2 at end.
- p0=l,o,l; feed l,o,3,l, then l,(sym_valid=0 for 4 cycles),o,l -> no match in the first run and fill=1 after it; exactly one match in the second run.
- COUNT_W=2: six lol matches -> hit_count[0] sticks at 3. Assert cnt_clear on the same cycle as a seventh match -> count=0, match pulse still seen.
- Feed l,o, drive reset low mid-stream for 2 cycles, release, feed l -> no match; fill=1; all counters 0; slot lengths read back as disabled (no match after reprogramming until a full pattern is re-entered).
